// File: rtl/motor_drive_pkg.sv
// Shared types, constants and duty-ramp helper for the dual H-bridge motor driver.
package motor_drive_pkg;

    localparam int unsigned ACTION_W = 4;
    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned DIR_W    = 2;

    // Action bit positions (one-hot command from the car controller)
    localparam int unsigned ACT_FWD   = 0;
    localparam int unsigned ACT_BWD   = 1;
    localparam int unsigned ACT_LEFT  = 2;
    localparam int unsigned ACT_RIGHT = 3;

    // Bridge input pair coding
    localparam logic [DIR_W-1:0] DIR_FWD   = 2'b10;
    localparam logic [DIR_W-1:0] DIR_REV   = 2'b01;
    localparam logic [DIR_W-1:0] DIR_COAST = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DEAD = 2'd3
    } state_e;

    // Decoded command: requested directions and duty target
    typedef struct packed {
        logic [DIR_W-1:0]  dir_a;
        logic [DIR_W-1:0]  dir_b;
        logic [DUTY_W-1:0] target;
        logic              stop;
    } cmd_t;

    // One saturating ramp step of duty toward target, 9-bit intermediate
    function automatic logic [DUTY_W-1:0] step_duty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] lim;
        up  = {1'b0, duty} + {1'b0, step};
        lim = {1'b0, target} + {1'b0, step};
        if (duty < target) begin
            return (up > {1'b0, target}) ? target : up[DUTY_W-1:0];
        end
        if ({1'b0, duty} > lim) begin
            return duty - step;
        end
        return target;
    endfunction

endpackage

// File: rtl/motor_drive_if.sv
// Command / bridge-drive bundle between the car controller and motor_drive.
interface motor_drive_if;
    import motor_drive_pkg::*;

    logic [ACTION_W-1:0] Action;
    logic [DIR_W-1:0]    dir_a;
    logic [DIR_W-1:0]    dir_b;
    logic                pwm_a;
    logic                pwm_b;
    logic                busy;

    modport master (
        output Action,
        input  dir_a, dir_b, pwm_a, pwm_b, busy
    );

    modport slave (
        input  Action,
        output dir_a, dir_b, pwm_a, pwm_b, busy
    );

endinterface

// File: rtl/motor_drive_pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; flags the last tick of every PWM period.
module motor_drive_pwm_timebase
    import motor_drive_pkg::*;
#(
    parameter int unsigned PRESCALE = 390
) (
    input  logic              clk_in,
    input  logic              rst_n,
    output logic [DUTY_W-1:0] pwm_cnt,
    output logic              period_end_c
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic              tick_c;

    // Next prescaler / counter values and period boundary
    always_comb begin
        tick_c       = (presc_q == PRE_W'(PRESCALE - 1));
        presc_d      = tick_c ? '0 : presc_q + PRE_W'(1);
        pwm_cnt_d    = tick_c ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        period_end_c = tick_c && (pwm_cnt_q == '1);
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/motor_drive.sv
// Action-to-H-bridge driver: direction pins, shared-duty PWM, soft ramp and reversal dead-time.
module motor_drive
    import motor_drive_pkg::*;
#(
    parameter int unsigned PRESCALE     = 390,
    parameter int unsigned RAMP_STEP    = 8,
    parameter int unsigned DEAD_PERIODS = 50,
    parameter int unsigned DUTY_RUN     = 200,
    parameter int unsigned DUTY_TURN    = 128
) (
    input  logic          clk_in,
    input  logic          rst_n,
    motor_drive_if.slave  bus
);

    localparam int unsigned DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;

    state_e             state_q, state_d;
    logic [DIR_W-1:0]   dir_a_q, dir_a_d;
    logic [DIR_W-1:0]   dir_b_q, dir_b_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
    logic               pwm_a_q, pwm_a_d;
    logic               pwm_b_q, pwm_b_d;
    logic               busy_q, busy_d;

    logic [DUTY_W-1:0]  pwm_cnt;
    logic               period_end_c;
    cmd_t               cmd_c;
    logic               reversal_c;
    logic [DUTY_W-1:0]  stepped_c;

    motor_drive_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .pwm_cnt      (pwm_cnt),
        .period_end_c (period_end_c)
    );

    // Decode Action into requested directions/target; anything not one-hot means stop
    always_comb begin
        cmd_c.dir_a  = dir_a_q;
        cmd_c.dir_b  = dir_b_q;
        cmd_c.target = '0;
        cmd_c.stop   = 1'b1;
        if ($onehot(bus.Action)) begin
            cmd_c.stop = 1'b0;
            if (bus.Action[ACT_FWD]) begin
                cmd_c.dir_a  = DIR_FWD;
                cmd_c.dir_b  = DIR_FWD;
                cmd_c.target = DUTY_W'(DUTY_RUN);
            end else if (bus.Action[ACT_BWD]) begin
                cmd_c.dir_a  = DIR_REV;
                cmd_c.dir_b  = DIR_REV;
                cmd_c.target = DUTY_W'(DUTY_RUN);
            end else if (bus.Action[ACT_LEFT]) begin
                cmd_c.dir_a  = DIR_REV;
                cmd_c.dir_b  = DIR_FWD;
                cmd_c.target = DUTY_W'(DUTY_TURN);
            end else if (bus.Action[ACT_RIGHT]) begin
                cmd_c.dir_a  = DIR_FWD;
                cmd_c.dir_b  = DIR_REV;
                cmd_c.target = DUTY_W'(DUTY_TURN);
            end
        end
        reversal_c = ((dir_a_q != DIR_COAST) && (cmd_c.dir_a != DIR_COAST) && (dir_a_q != cmd_c.dir_a))
                  || ((dir_b_q != DIR_COAST) && (cmd_c.dir_b != DIR_COAST) && (dir_b_q != cmd_c.dir_b));
        stepped_c  = step_duty(duty_q, cmd_c.target, DUTY_W'(RAMP_STEP));
    end

    // Next-state, duty and direction; everything advances only at period end
    always_comb begin
        state_d    = state_q;
        dir_a_d    = dir_a_q;
        dir_b_d    = dir_b_q;
        duty_d     = duty_q;
        dead_cnt_d = dead_cnt_q;

        if (period_end_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (!cmd_c.stop) begin
                        dir_a_d = cmd_c.dir_a;
                        dir_b_d = cmd_c.dir_b;
                        duty_d  = stepped_c;
                        state_d = (stepped_c == cmd_c.target) ? ST_RUN : ST_RAMP;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (reversal_c) begin
                        state_d    = ST_DEAD;
                        duty_d     = '0;
                        dir_a_d    = DIR_COAST;
                        dir_b_d    = DIR_COAST;
                        dead_cnt_d = DEAD_W'(DEAD_PERIODS);
                    end else begin
                        duty_d = stepped_c;
                        if (stepped_c != cmd_c.target) begin
                            state_d = ST_RAMP;
                        end else if (cmd_c.stop) begin
                            state_d = ST_IDLE;
                            dir_a_d = DIR_COAST;
                            dir_b_d = DIR_COAST;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_q <= DEAD_W'(1)) begin
                        dead_cnt_d = '0;
                        if (cmd_c.stop) begin
                            state_d = ST_IDLE;
                        end else begin
                            dir_a_d = cmd_c.dir_a;
                            dir_b_d = cmd_c.dir_b;
                            duty_d  = stepped_c;
                            state_d = (stepped_c == cmd_c.target) ? ST_RUN : ST_RAMP;
                        end
                    end else begin
                        dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d  = (state_d == ST_RAMP) || (state_d == ST_DEAD);
        pwm_a_d = (pwm_cnt < duty_q);
        pwm_b_d = (pwm_cnt < duty_q);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_a_q    <= DIR_COAST;
            dir_b_q    <= DIR_COAST;
            duty_q     <= '0;
            dead_cnt_q <= '0;
            pwm_a_q    <= 1'b0;
            pwm_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_a_q    <= dir_a_d;
            dir_b_q    <= dir_b_d;
            duty_q     <= duty_d;
            dead_cnt_q <= dead_cnt_d;
            pwm_a_q    <= pwm_a_d;
            pwm_b_q    <= pwm_b_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.dir_a = dir_a_q;
    assign bus.dir_b = dir_b_q;
    assign bus.pwm_a = pwm_a_q;
    assign bus.pwm_b = pwm_b_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_motor_drive.sv
// Self-checking bench for motor_drive: per-period scoreboard of dirs, busy and PWM high time.
module tb_motor_drive;

    localparam int unsigned PRESCALE     = 2;
    localparam int unsigned RAMP_STEP    = 64;
    localparam int unsigned DEAD_PERIODS = 2;
    localparam int unsigned DUTY_RUN     = 200;
    localparam int unsigned DUTY_TURN    = 128;
    localparam int unsigned PERIOD       = PRESCALE * 256;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEAD = 3;

    typedef struct {
        logic [1:0]  prev_da;
        logic [1:0]  prev_db;
        logic [1:0]  da;
        logic [1:0]  db;
        logic        busy;
        int unsigned pwm_hi;
    } exp_t;

    logic clk_in;
    logic rst_n;

    motor_drive_if bus ();

    motor_drive #(
        .PRESCALE     (PRESCALE),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS),
        .DUTY_RUN     (DUTY_RUN),
        .DUTY_TURN    (DUTY_TURN)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int unsigned n_cmp;
    int unsigned n_err;
    exp_t        sb_q[$];

    // Reference model state
    int          m_state;
    int unsigned m_duty;
    int unsigned m_dead;
    logic [1:0]  m_da;
    logic [1:0]  m_db;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ramp(input int unsigned d, input int unsigned t);
        if (t > d) return (d + RAMP_STEP > t) ? t : d + RAMP_STEP;
        if (d > t + RAMP_STEP) return d - RAMP_STEP;
        return t;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_duty  = 0;
        m_dead  = 0;
        m_da    = 2'b00;
        m_db    = 2'b00;
    endtask

    // One period_end of the reference behaviour
    task automatic model_step(input logic [3:0] act);
        logic [1:0]  ra;
        logic [1:0]  rb;
        int unsigned tgt;
        bit          stop;
        bit          rev;
        stop = 1'b0;
        case (act)
            4'b0001: begin ra = 2'b10; rb = 2'b10; tgt = DUTY_RUN;  end
            4'b0010: begin ra = 2'b01; rb = 2'b01; tgt = DUTY_RUN;  end
            4'b0100: begin ra = 2'b01; rb = 2'b10; tgt = DUTY_TURN; end
            4'b1000: begin ra = 2'b10; rb = 2'b01; tgt = DUTY_TURN; end
            default: begin ra = m_da;  rb = m_db;  tgt = 0; stop = 1'b1; end
        endcase
        rev = (m_da != 2'b00 && ra != 2'b00 && m_da != ra) ||
              (m_db != 2'b00 && rb != 2'b00 && m_db != rb);
        case (m_state)
            M_IDLE: begin
                if (!stop) begin
                    m_da    = ra;
                    m_db    = rb;
                    m_duty  = ramp(m_duty, tgt);
                    m_state = (m_duty == tgt) ? M_RUN : M_RAMP;
                end
            end
            M_RAMP, M_RUN: begin
                if (rev) begin
                    m_state = M_DEAD;
                    m_duty  = 0;
                    m_da    = 2'b00;
                    m_db    = 2'b00;
                    m_dead  = DEAD_PERIODS;
                end else begin
                    m_duty = ramp(m_duty, tgt);
                    if (m_duty != tgt) begin
                        m_state = M_RAMP;
                    end else if (tgt == 0) begin
                        m_state = M_IDLE;
                        m_da    = 2'b00;
                        m_db    = 2'b00;
                    end else begin
                        m_state = M_RUN;
                    end
                end
            end
            default: begin
                m_dead = m_dead - 1;
                if (m_dead == 0) begin
                    if (stop) begin
                        m_state = M_IDLE;
                    end else begin
                        m_da    = ra;
                        m_db    = rb;
                        m_duty  = ramp(0, tgt);
                        m_state = (m_duty == tgt) ? M_RUN : M_RAMP;
                    end
                end
            end
        endcase
    endtask

    // Hold rst_n low for n cycles; outputs must be zero after every reset edge
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check_eq("rst_dir_a", 32'(bus.dir_a), 0);
            check_eq("rst_dir_b", 32'(bus.dir_b), 0);
            check_eq("rst_pwm_a", 32'(bus.pwm_a), 0);
            check_eq("rst_pwm_b", 32'(bus.pwm_b), 0);
            check_eq("rst_busy",  32'(bus.busy),  0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // One full PWM period ending on a period_end edge; glitch is driven for cycles 100..299
    task automatic step(input logic [3:0] act, input logic [3:0] glitch);
        exp_t        e;
        int unsigned hi_a;
        int unsigned hi_b;
        logic [1:0]  pre_a;
        logic [1:0]  pre_b;
        e.prev_da = m_da;
        e.prev_db = m_db;
        e.pwm_hi  = 2 * m_duty;
        model_step(act);
        e.da   = m_da;
        e.db   = m_db;
        e.busy = (m_state == M_RAMP) || (m_state == M_DEAD);
        sb_q.push_back(e);
        hi_a  = 0;
        hi_b  = 0;
        pre_a = 2'b00;
        pre_b = 2'b00;
        for (int i = 1; i <= int'(PERIOD); i++) begin
            bus.Action = (i >= 100 && i < 300) ? glitch : act;
            @(posedge clk_in);
            @(negedge clk_in);
            if (bus.pwm_a === 1'b1) hi_a++;
            if (bus.pwm_b === 1'b1) hi_b++;
            if (i == int'(PERIOD) - 1) begin
                pre_a = bus.dir_a;
                pre_b = bus.dir_b;
            end
        end
        e = sb_q.pop_front();
        check_eq("hold_dir_a", 32'(pre_a), 32'(e.prev_da));
        check_eq("hold_dir_b", 32'(pre_b), 32'(e.prev_db));
        check_eq("pwm_a_high", hi_a, e.pwm_hi);
        check_eq("pwm_b_high", hi_b, e.pwm_hi);
        check_eq("dir_a",      32'(bus.dir_a), 32'(e.da));
        check_eq("dir_b",      32'(bus.dir_b), 32'(e.db));
        check_eq("busy",       32'(bus.busy),  32'(e.busy));
    endtask

    task automatic steps(input logic [3:0] act, input int n);
        for (int k = 0; k < n; k++) step(act, act);
    endtask

    // Run part of a period, then pulse reset for one cycle
    task automatic reset_mid(input int ncyc);
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
        end
        rst_n = 1'b0;
        check_eq("pre_rst_dir_a", 32'(bus.dir_a), 32'(m_da));
        check_eq("pre_rst_busy",  32'(bus.busy),  (m_state == M_RAMP || m_state == M_DEAD) ? 1 : 0);
        check_eq("pre_rst_pwm_a", 32'(bus.pwm_a), (((ncyc - 1) / 2) < int'(m_duty)) ? 1 : 0);
        @(posedge clk_in);
        @(negedge clk_in);
        check_eq("mid_rst_dir_a", 32'(bus.dir_a), 0);
        check_eq("mid_rst_dir_b", 32'(bus.dir_b), 0);
        check_eq("mid_rst_pwm_a", 32'(bus.pwm_a), 0);
        check_eq("mid_rst_pwm_b", 32'(bus.pwm_b), 0);
        check_eq("mid_rst_busy",  32'(bus.busy),  0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.Action = 4'b0001;
        model_reset();

        do_reset(3);

        // Forward ramp up to RUN, then one period at full run duty
        steps(4'b0001, 5);
        // Reversal to backward: dead-time, then ramp up again
        steps(4'b0010, 7);
        // Stop: ramp down to IDLE
        steps(4'b0000, 5);
        // Forward again, then a short backward glitch that must be ignored
        steps(4'b0001, 4);
        step(4'b0001, 4'b0010);
        // Multi-hot behaves as stop, no dead-time
        steps(4'b0011, 5);
        // Left spin, reversal to right, stop during dead-time
        steps(4'b0100, 3);
        step(4'b1000, 4'b1000);
        steps(4'b0000, 3);
        // Forward ramp to 128, then reset mid-period
        steps(4'b0001, 2);
        reset_mid(100);
        steps(4'b0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Downstream consumer of the car control block's 4-bit Action command.
- Converts Action into direction pins and two PWM enables for a dual H-bridge (L298N style): left motor A, right motor B.
- Adds soft-start/stop duty ramping and a coast dead-time on every direction reversal so the bridge never switches polarity under load.

Parameters:
- PRESCALE, 390, clk_in cycles per PWM counter tick (100 MHz / (390*256) ≈ 1 kHz PWM).
- RAMP_STEP, 8, duty change per PWM period while ramping (8-bit units).
- DEAD_PERIODS, 50, PWM periods of forced coast on direction reversal.
- DUTY_RUN, 200, target duty for forward/backward.
- DUTY_TURN, 128, target duty for left/right spin.

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- Action  input  4  command, one-hot: [0] forward, [1] backward, [2] left, [3] right; zero or multi-hot = stop
- dir_a  output  2  left motor IN1/IN2: 10 forward, 01 reverse, 00 coast
- dir_b  output  2  right motor IN3/IN4, same coding
- pwm_a  output  1  left motor enable PWM
- pwm_b  output  1  right motor enable PWM
- busy  output  1  high in any state except IDLE and RUN

Behaviour:
- Reset: one clock, synchronous, active low; sampled only on clk_in rising edge.
  - On reset: dir_a = dir_b = 00, pwm_a = pwm_b = 0, duty = 0, counters = 0, state IDLE, busy = 0.
  - Reset mid-operation behaves identically; there is no ramp-down.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; tick on terminal count.
  - 8-bit pwm_cnt increments on tick and wraps 255→0.
  - period_end = tick && pwm_cnt==255.
- PWM output: pwm_x = (pwm_cnt < duty_x), registered.
  - duty 0 gives constant 0; duty 255 gives high for 255 of 256 ticks.
- Update timing:
  - Action is sampled and state, duty and direction update only on period_end. No mid-period duty change.
  - Action changes shorter than one period are ignored.
- Target per command (dir_a, dir_b, target):
  - forward: 10, 10, DUTY_RUN
  - backward: 01, 01, DUTY_RUN
  - left: 01, 10, DUTY_TURN
  - right: 10, 01, DUTY_TURN
  - stop: current dirs held, target 0
- Duty arithmetic: 9-bit intermediate, saturating.
  - Up: duty = min(duty+RAMP_STEP, target).
  - Down: duty = (duty > target+RAMP_STEP) ? duty-RAMP_STEP : target.
  - Both motors always share one duty value.
- FSM, evaluated at period_end:
  - IDLE: dirs 00, duty 0.
    - Non-stop command → load dirs, RAMP.
  - RAMP: step duty toward target.
    - duty reaches target, target ≠ 0 → RUN.
    - duty reaches 0 with stop → IDLE; dirs go 00 on IDLE entry.
    - Reversal requested → DEAD.
    - Same-direction target change (e.g. forward→stop→forward) → stay in RAMP, retarget.
  - RUN: hold duty.
    - Target differs with same dirs → RAMP.
    - Reversal → DEAD.
  - DEAD: entry forces duty 0 and dirs 00 at the same period_end; dead counter loads DEAD_PERIODS.
    - Counter decrements each period_end.
    - At 0: latest sampled command applied; stop → IDLE, else load dirs → RAMP from duty 0.
    - Commands arriving during DEAD never restart or shorten the count.
- Reversal definition: for either motor, current dir ≠ 00 and requested dir ≠ 00 and they differ.
- Simultaneous events: reset dominates everything. period_end in the same cycle as an Action change uses the new Action value.

Decomposition:
- Shared package:
  - Action bit indices.
  - DIR_FWD=2'b10, DIR_REV=2'b01, DIR_COAST=2'b00.
  - FSM state encoding: IDLE, RAMP, RUN, DEAD.
- Sub-module pwm_timebase: prescaler plus pwm_cnt; outputs pwm_cnt[7:0] and period_end.

Test Plan (PRESCALE=2, RAMP_STEP=64, DEAD_PERIODS=2, DUTY_RUN=200, DUTY_TURN=128; period = 512 cycles):
- Reset held 3 cycles, Action=0001 → all outputs 0 during reset; first change occurs only at the first period_end after release.
- From IDLE, Action=0001 → dir_a = dir_b = 10; duty 64, 128, 192, 200 on successive periods; RUN; pwm_a high exactly 400 cycles per period at 200.
- RUN forward, Action=0010 → next period_end: dirs 00, duty 0, busy=1; 2 periods coast; then dirs 01, duty ramps 64 → 200.
- RUN at 200, Action=0000 → duty 136, 72, 8, 0; then IDLE, dirs 00, busy=0.
- Action=0011 (multi-hot) from RUN forward → treated as stop; ramps down, no DEAD entry.
- rst_n low for one cycle mid-RAMP at duty 128 → outputs unchanged until that clock edge, all zero after it; state IDLE.
